// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, reset/NOP words, fetch FSM encoding,
// RV32I major opcodes and small PC helpers used by fetch and decode.
package cpu_pkg;

    localparam int XLEN = 32;

    // ADDI x0,x0,0 -- the canonical RV32I no-op
    localparam logic [XLEN-1:0] CPU_NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] CPU_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP       = 32'd4;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_e;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Force an address onto a word boundary
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

    // True when an address is not word aligned
    function automatic logic is_misaligned(input logic [XLEN-1:0] a);
        return |a[1:0];
    endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues word reads over req/ack and
// hands each instruction with its PC to decode under valid/stall. Redirects
// from execute flush the output; a request already on the bus is never
// withdrawn, so a redirect that catches one in flight drains it first.
module fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = CPU_RESET_PC,
    parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        valid,
    output logic        misaligned
);

    fetch_state_e r_state;
    logic         r_pending;    // request was on the bus last cycle without ack
    logic [31:0]  r_req_addr;   // address of that request
    logic [31:0]  r_fetch_pc;   // next address to fetch
    logic [31:0]  r_instr;
    logic [31:0]  r_pc;
    logic         r_valid;
    logic         r_mis;

    logic         w_req;
    logic [31:0]  w_addr;
    logic         w_ack;
    logic         w_accept;
    logic         w_consume;
    logic [31:0]  w_pc_inc;

    // Request: forced high while pending or draining; otherwise issued in
    // FETCH only when the output slot is free or being consumed this cycle.
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            FS_IDLE:  w_req = 1'b0;
            FS_FETCH: w_req = r_pending | ~(r_valid & stall);
            FS_DRAIN: w_req = 1'b1;
            default:  w_req = 1'b0;
        endcase
    end

    // A pending request keeps its original address on the bus
    assign w_addr    = r_pending ? r_req_addr : r_fetch_pc;
    assign w_ack     = w_req & mem_ack;
    assign w_accept  = (r_state == FS_FETCH) & w_ack & ~redirect;
    assign w_consume = r_valid & ~stall;
    assign w_pc_inc  = r_fetch_pc + PC_STEP;

    // Sequencer and outstanding-request tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= FS_IDLE;
            r_pending  <= 1'b0;
            r_req_addr <= RESET_PC;
        end else begin
            r_pending <= w_req & ~mem_ack;
            if (w_req)
                r_req_addr <= w_addr;
            case (r_state)
                FS_IDLE:  r_state <= FS_FETCH;
                // redirect with an unanswered request must wait for its ack
                FS_FETCH: r_state <= (redirect && w_req && !mem_ack) ? FS_DRAIN : FS_FETCH;
                // stale ack arrives: its data is simply not captured
                FS_DRAIN: r_state <= w_ack ? FS_FETCH : FS_DRAIN;
                default:  r_state <= FS_IDLE;
            endcase
        end
    end

    // PC and decode-facing output register; redirect beats accept and stall
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_mis      <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc <= word_align(redirect_pc);
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            if (is_misaligned(redirect_pc))
                r_mis <= 1'b1;
        end else if (w_accept) begin
            r_instr    <= mem_rdata;
            r_pc       <= r_fetch_pc;
            r_valid    <= 1'b1;
            r_fetch_pc <= w_pc_inc;
        end else if (w_consume) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
        end
    end

    assign mem_req     = w_req;
    assign mem_addr    = w_addr;
    assign instruction = r_instr;
    assign pc          = r_pc;
    assign valid       = r_valid;
    assign misaligned  = r_mis;

endmodule
